rice_bus_arbiter: RTL and testbench
===================================

Name: rice_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the rice bus request/response protocol.
- Sits between several bus masters (e.g. instruction fetch, load/store, debug) and one shared slave port.
- Round-robin grant on the request channel; an in-order ID FIFO steers each response back to the master whose request was accepted.
- Zero added latency on both channels (combinational pass-through of the granted master).

Parameters:
- MASTERS, 2, number of requesters (≥2).
- ADDRESS_WIDTH, 32, address bits.
- DATA_WIDTH, 32, write/read data bits.
- STROBE_WIDTH, DATA_WIDTH/8, byte strobe bits.
- MAX_OUTSTANDING, 4, accepted-but-unanswered requests allowed (≥1).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: one clock; reset is synchronous and active-high.
- i_request_valid  in  MASTERS  per-master request valid.
- o_request_ready  out  MASTERS  per-master request ready.
- i_address  in  MASTERS*ADDRESS_WIDTH  packed, master m at [m*AW +: AW].
- i_strobe  in  MASTERS*STROBE_WIDTH  packed per master.
- i_write_data  in  MASTERS*DATA_WIDTH  packed per master.
- o_response_valid  out  MASTERS  per-master response valid.
- i_response_ready  in  MASTERS  per-master response ready.
- o_read_data  out  DATA_WIDTH  broadcast to all masters.
- o_error  out  1  broadcast.
- o_slave_request_valid  out  1.
- i_slave_request_ready  in  1.
- o_slave_address  out  ADDRESS_WIDTH.
- o_slave_strobe  out  STROBE_WIDTH.
- o_slave_write_data  out  DATA_WIDTH.
- i_slave_response_valid  in  1.
- o_slave_response_ready  out  1.
- i_slave_read_data  in  DATA_WIDTH.
- i_slave_error  in  1.

Behaviour:
- Reset (i_rst=1 at posedge): rr pointer=0, lock=0, FIFO empty (count=0). All ready/valid outputs are 0 while FIFO empty and no master valid.
- Grant, unlocked: first requesting master at or after the rr pointer (modulo MASTERS).
- Grant, locked: previous grant held.
- Lock set when o_slave_request_valid=1 and i_slave_request_ready=0; cleared on acceptance. A pending request is never re-arbitrated.
- o_slave_request_valid = any valid && !full_block. The slave address/strobe/data come from the granted master.
- o_request_ready[g] = i_slave_request_ready && !full_block for the granted master g only; 0 for all other masters.
- Accept = slave valid && ready. On accept: push g into the ID FIFO and set rr pointer to (g+1) mod MASTERS.
- full_block = (count==MAX_OUTSTANDING) && !pop. A pop and a push in the same cycle are allowed at full and leave count unchanged.
- Response path, FIFO non-empty with head h:
  - o_response_valid[h] = i_slave_response_valid.
  - o_slave_response_ready = i_response_ready[h].
  - All other response valids are 0.
- Pop = i_slave_response_valid && o_slave_response_ready.
- FIFO empty: o_slave_response_ready=0 and all o_response_valid=0. A slave response arriving with the FIFO empty is a protocol violation and must be flagged by an assertion.
- Responses are strictly in acceptance order. The slave must respond in order.
- Simultaneous push and pop at count 0 is impossible, because a response requires a prior accept.
- Reset asserted mid-transaction discards the FIFO contents and the lock. The bench resets the slave at the same time.
- Count width: $clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.

Decomposition:
- Package rice_bus_arbiter_pkg holds the ID width function (clog2(MASTERS), minimum 1).
- Sub-module rice_bus_arbiter_id_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, data, pop, head, empty, full, count.
  - Same clock and reset as the arbiter; depth = MAX_OUTSTANDING.
- Round-robin grant logic stays inline in the top module.

Test Plan:
- Masters 0 and 1 both hold valid, slave always ready, responses immediate → grants alternate 0,1,0,1; each response reaches the correct master with matching i_slave_read_data.
- Master 1 valid with slave ready=0 for 3 cycles, master 0 raises valid in cycle 2 → grant stays on 1 until accept; master 0 granted next cycle; the address observed on the slave is stable during the stall.
- MAX_OUTSTANDING=4, slave accepts and withholds responses → after 4 accepts o_slave_request_valid=0 and o_request_ready=0; the first response re-enables requests in the same cycle.
- Master 0 holds i_response_ready=0 for 2 cycles while the slave presents its response → o_slave_response_ready=0 and data is held; pop occurs on the cycle ready rises.
- i_rst asserted with 2 outstanding → next cycle count=0, no response valids; first request after reset is granted to master 0.
- Slave returns i_slave_error=1 on the 2nd of 3 ordered responses → o_error=1 only with o_response_valid of that request's master.

Source files
------------

// File: rtl/rice_bus_arbiter_pkg.sv
// Shared definitions for the rice bus arbiter.
// id_width: bits needed to name one of `masters` requesters (never less than 1).
package rice_bus_arbiter_pkg;

  function automatic int unsigned id_width(input int unsigned masters);
    return (masters > 2) ? $clog2(masters) : 1;
  endfunction

endpackage

// File: rtl/rice_bus_arbiter_id_fifo.sv
// In-order ID FIFO: remembers which master owns each accepted-but-unanswered request.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_data write one ID at the tail
//   i_pop         drop the head entry
//   o_head        ID at the head (valid when !o_empty)
//   o_empty/o_full/o_count occupancy
module rice_bus_arbiter_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PtrWidth   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountWidth = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = i_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = i_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({i_push, i_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CountWidth'(DEPTH));
  assign o_count = count_q;

endmodule

// File: rtl/rice_bus_arbiter.sv
// N-master to 1-slave rice bus arbiter.
// Round-robin grant on the request channel, held while the slave stalls; an in-order
// ID FIFO routes each slave response back to the master whose request was accepted.
// Both channels are combinational pass-throughs (no added latency).
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_request_valid/o_request_ready    per-master request handshake
//   i_address/i_strobe/i_write_data    packed per-master request payload
//   o_response_valid/i_response_ready  per-master response handshake
//   o_read_data, o_error               response payload broadcast to all masters
//   o_slave_*/i_slave_*                shared slave port
module rice_bus_arbiter
  import rice_bus_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS         = 2,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STROBE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [MASTERS-1:0]                 i_request_valid,
  output logic [MASTERS-1:0]                 o_request_ready,
  input  logic [MASTERS*ADDRESS_WIDTH-1:0]   i_address,
  input  logic [MASTERS*STROBE_WIDTH-1:0]    i_strobe,
  input  logic [MASTERS*DATA_WIDTH-1:0]      i_write_data,
  output logic [MASTERS-1:0]                 o_response_valid,
  input  logic [MASTERS-1:0]                 i_response_ready,
  output logic [DATA_WIDTH-1:0]              o_read_data,
  output logic                               o_error,
  output logic                               o_slave_request_valid,
  input  logic                               i_slave_request_ready,
  output logic [ADDRESS_WIDTH-1:0]           o_slave_address,
  output logic [STROBE_WIDTH-1:0]            o_slave_strobe,
  output logic [DATA_WIDTH-1:0]              o_slave_write_data,
  input  logic                               i_slave_response_valid,
  output logic                               o_slave_response_ready,
  input  logic [DATA_WIDTH-1:0]              i_slave_read_data,
  input  logic                               i_slave_error
);

  localparam int unsigned IdWidth    = id_width(MASTERS);
  localparam int unsigned CountWidth = $clog2(MAX_OUTSTANDING + 1);

  logic [IdWidth-1:0]    rr_q, rr_d;
  logic [IdWidth-1:0]    grant_q;
  logic                  lock_q, lock_d;
  logic [IdWidth-1:0]    grant;
  logic                  any_valid;
  logic                  full_block;
  logic                  accept;
  logic                  pop;
  logic [IdWidth-1:0]    fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CountWidth-1:0] fifo_count;

  assign any_valid = |i_request_valid;

  // Locked: the slave saw a request it has not yet taken, so the grant must not move.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    grant = rr_q;
    if (lock_q) begin
      grant = grant_q;
    end else begin
      for (int unsigned i = 0; i < MASTERS; i++) begin
        idx = (int'(rr_q) + i) % MASTERS;
        if (!found && i_request_valid[idx]) begin
          grant = IdWidth'(idx);
          found = 1'b1;
        end
      end
    end
  end

  // A simultaneous pop frees a slot, so a full FIFO can still accept this cycle.
  assign full_block = (fifo_count == CountWidth'(MAX_OUTSTANDING)) && !pop;

  assign o_slave_request_valid = any_valid && !full_block;
  assign o_slave_address    = i_address[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign o_slave_strobe     = i_strobe[int'(grant)*STROBE_WIDTH +: STROBE_WIDTH];
  assign o_slave_write_data = i_write_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign accept = o_slave_request_valid && i_slave_request_ready;

  always_comb begin
    o_request_ready        = '0;
    o_request_ready[grant] = any_valid && i_slave_request_ready && !full_block;
  end

  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    if (accept) begin
      rr_d   = (int'(grant) + 1 == MASTERS) ? '0 : IdWidth'(int'(grant) + 1);
      lock_d = 1'b0;
    end else if (o_slave_request_valid) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q    <= '0;
      lock_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      grant_q <= grant;
    end
  end

  // Response path: only the head-of-FIFO master sees the slave response.
  always_comb begin
    o_response_valid       = '0;
    o_slave_response_ready = 1'b0;
    if (!fifo_empty) begin
      o_response_valid[fifo_head] = i_slave_response_valid;
      o_slave_response_ready      = i_response_ready[fifo_head];
    end
  end

  assign pop         = i_slave_response_valid && o_slave_response_ready;
  assign o_read_data = i_slave_read_data;
  assign o_error     = i_slave_error;

  rice_bus_arbiter_id_fifo #(
    .WIDTH (IdWidth),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (accept),
    .i_data  (grant),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  // A response with nothing outstanding means the slave broke ordering.
  assert property (@(posedge i_clk) disable iff (i_rst) !(i_slave_response_valid && fifo_empty))
    else $error("slave response with no outstanding request");

  assert property (@(posedge i_clk) disable iff (i_rst)
                   fifo_full == (fifo_count == CountWidth'(MAX_OUTSTANDING)))
    else $error("id fifo full flag disagrees with count");

endmodule

// File: tb/tb_rice_bus_arbiter.sv
module tb_rice_bus_arbiter;

  localparam int unsigned Masters = 2;
  localparam int unsigned Aw      = 32;
  localparam int unsigned Dw      = 32;
  localparam int unsigned Sw      = Dw / 8;
  localparam int unsigned MaxOut  = 4;

  logic                    clk;
  logic                    rst;
  logic [Masters-1:0]      request_valid;
  logic [Masters-1:0]      request_ready;
  logic [Masters*Aw-1:0]   address;
  logic [Masters*Sw-1:0]   strobe;
  logic [Masters*Dw-1:0]   write_data;
  logic [Masters-1:0]      response_valid;
  logic [Masters-1:0]      response_ready;
  logic [Dw-1:0]           read_data;
  logic                    error;
  logic                    slave_request_valid;
  logic                    slave_request_ready;
  logic [Aw-1:0]           slave_address;
  logic [Sw-1:0]           slave_strobe;
  logic [Dw-1:0]           slave_write_data;
  logic                    slave_response_valid;
  logic                    slave_response_ready;
  logic [Dw-1:0]           slave_read_data;
  logic                    slave_error;

  int n_checks = 0;
  int n_fail   = 0;

  rice_bus_arbiter #(
    .MASTERS         (Masters),
    .ADDRESS_WIDTH   (Aw),
    .DATA_WIDTH      (Dw),
    .STROBE_WIDTH    (Sw),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_request_valid        (request_valid),
    .o_request_ready        (request_ready),
    .i_address              (address),
    .i_strobe               (strobe),
    .i_write_data           (write_data),
    .o_response_valid       (response_valid),
    .i_response_ready       (response_ready),
    .o_read_data            (read_data),
    .o_error                (error),
    .o_slave_request_valid  (slave_request_valid),
    .i_slave_request_ready  (slave_request_ready),
    .o_slave_address        (slave_address),
    .o_slave_strobe         (slave_strobe),
    .o_slave_write_data     (slave_write_data),
    .i_slave_response_valid (slave_response_valid),
    .o_slave_response_ready (slave_response_ready),
    .i_slave_read_data      (slave_read_data),
    .i_slave_error          (slave_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled 3 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    rst                  = 1'b1;
    request_valid        = '0;
    address              = {32'h0000_2000, 32'h0000_1000};
    strobe               = {4'hC, 4'h3};
    write_data           = {32'hBBBB_0001, 32'hAAAA_0000};
    response_ready       = 2'b11;
    slave_request_ready  = 1'b0;
    slave_response_valid = 1'b0;
    slave_read_data      = '0;
    slave_error          = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    settle();
    check_eq("rst_req_ready", 32'(request_ready), 32'h0);
    check_eq("rst_slv_valid", 32'(slave_request_valid), 32'h0);
    check_eq("rst_rsp_valid", 32'(response_valid), 32'h0);
    check_eq("rst_slv_rsp_ready", 32'(slave_response_ready), 32'h0);
    check_eq("rst_count", 32'(dut.fifo_count), 32'h0);
    tick();

    // Alternating grants with immediate responses
    request_valid       = 2'b11;
    slave_request_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      slave_response_valid = (k > 0);
      slave_read_data      = 32'h0000_00D0 + 32'(k);
      settle();
      check_eq($sformatf("alt_ready_%0d", k), 32'(request_ready),
               (k % 2 == 0) ? 32'h1 : 32'h2);
      check_eq($sformatf("alt_addr_%0d", k), slave_address,
               (k % 2 == 0) ? 32'h1000 : 32'h2000);
      check_eq($sformatf("alt_strb_%0d", k), 32'(slave_strobe),
               (k % 2 == 0) ? 32'h3 : 32'hC);
      if (k > 0) begin
        check_eq($sformatf("alt_rsp_%0d", k), 32'(response_valid),
                 ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
        check_eq($sformatf("alt_rdata_%0d", k), read_data, 32'h0000_00D0 + 32'(k));
      end
      tick();
    end
    request_valid        = 2'b00;
    slave_response_valid = 1'b1;
    settle();
    check_eq("alt_drain_rsp", 32'(response_valid), 32'h2);
    tick();
    slave_response_valid = 1'b0;

    // Stall: grant on master 1 must hold while slave is not ready
    request_valid       = 2'b10;
    slave_request_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) request_valid = 2'b11;
      settle();
      check_eq($sformatf("stall_valid_%0d", k), 32'(slave_request_valid), 32'h1);
      check_eq($sformatf("stall_ready_%0d", k), 32'(request_ready), 32'h0);
      check_eq($sformatf("stall_addr_%0d", k), slave_address, 32'h2000);
      tick();
    end
    slave_request_ready = 1'b1;
    settle();
    check_eq("stall_accept_ready", 32'(request_ready), 32'h2);
    check_eq("stall_accept_addr", slave_address, 32'h2000);
    tick();
    request_valid = 2'b01;
    settle();
    check_eq("stall_next_ready", 32'(request_ready), 32'h1);
    check_eq("stall_next_addr", slave_address, 32'h1000);
    tick();
    request_valid        = 2'b00;
    slave_response_valid = 1'b1;
    settle();
    check_eq("stall_rsp0", 32'(response_valid), 32'h2);
    tick();
    settle();
    check_eq("stall_rsp1", 32'(response_valid), 32'h1);
    tick();
    slave_response_valid = 1'b0;

    // Fill to MAX_OUTSTANDING, then a response reopens the request path
    request_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_eq($sformatf("fill_ready_%0d", k), 32'(request_ready), 32'h1);
      tick();
    end
    settle();
    check_eq("full_slv_valid", 32'(slave_request_valid), 32'h0);
    check_eq("full_req_ready", 32'(request_ready), 32'h0);
    check_eq("full_count", 32'(dut.fifo_count), 32'h4);
    slave_response_valid = 1'b1;
    settle();
    check_eq("full_pop_slv_valid", 32'(slave_request_valid), 32'h1);
    check_eq("full_pop_req_ready", 32'(request_ready), 32'h1);
    check_eq("full_pop_rsp", 32'(response_valid), 32'h1);
    tick();
    request_valid = 2'b00;
    settle();
    check_eq("full_pushpop_count", 32'(dut.fifo_count), 32'h4);
    for (int k = 0; k < 4; k++) begin
      settle();
      check_eq($sformatf("full_drain_%0d", k), 32'(response_valid), 32'h1);
      tick();
    end
    slave_response_valid = 1'b0;
    settle();
    check_eq("full_drained_count", 32'(dut.fifo_count), 32'h0);

    // Response backpressure from master 0
    request_valid = 2'b01;
    tick();
    request_valid        = 2'b00;
    slave_response_valid = 1'b1;
    slave_read_data      = 32'h0000_CAFE;
    response_ready       = 2'b00;
    for (int k = 0; k < 2; k++) begin
      settle();
      check_eq($sformatf("bp_slv_ready_%0d", k), 32'(slave_response_ready), 32'h0);
      check_eq($sformatf("bp_rsp_%0d", k), 32'(response_valid), 32'h1);
      check_eq($sformatf("bp_rdata_%0d", k), read_data, 32'h0000_CAFE);
      tick();
    end
    check_eq("bp_count_held", 32'(dut.fifo_count), 32'h1);
    response_ready = 2'b01;
    settle();
    check_eq("bp_slv_ready_up", 32'(slave_response_ready), 32'h1);
    tick();
    slave_response_valid = 1'b0;
    response_ready       = 2'b11;
    settle();
    check_eq("bp_popped_count", 32'(dut.fifo_count), 32'h0);

    // Reset with two outstanding
    request_valid = 2'b11;
    settle();
    check_eq("rst2_grant_a", 32'(request_ready), 32'h2);
    tick();
    settle();
    check_eq("rst2_grant_b", 32'(request_ready), 32'h1);
    tick();
    request_valid = 2'b00;
    check_eq("rst2_count_pre", 32'(dut.fifo_count), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_eq("rst2_count", 32'(dut.fifo_count), 32'h0);
    check_eq("rst2_rsp_valid", 32'(response_valid), 32'h0);
    check_eq("rst2_slv_rsp_ready", 32'(slave_response_ready), 32'h0);
    request_valid = 2'b11;
    settle();
    check_eq("rst2_first_grant", 32'(request_ready), 32'h1);
    tick();
    request_valid        = 2'b00;
    slave_response_valid = 1'b1;
    settle();
    check_eq("rst2_rsp", 32'(response_valid), 32'h1);
    tick();
    slave_response_valid = 1'b0;

    // Error on the 2nd of 3 ordered responses (grants: m1, m0, m1)
    request_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq($sformatf("err_grant_%0d", k), 32'(request_ready),
               (k == 1) ? 32'h1 : 32'h2);
      tick();
    end
    request_valid        = 2'b00;
    slave_response_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      slave_error = (k == 1);
      settle();
      check_eq($sformatf("err_rsp_%0d", k), 32'(response_valid), (k == 1) ? 32'h1 : 32'h2);
      check_eq($sformatf("err_flag_%0d", k), 32'(error), (k == 1) ? 32'h1 : 32'h0);
      tick();
    end
    slave_response_valid = 1'b0;
    slave_error          = 1'b0;
    settle();
    check_eq("err_done_count", 32'(dut.fifo_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
